cpuc_ram_ctrl: RTL
==================

Name: cpuc_ram_ctrl

Overview:
- Initiator side of the CPUC single-port RAM interface: the block that drives address/wren/data into the RAM and samples its asynchronous read data.
- Arbitrates two valid/ready requesters onto the one port:
  - instruction fetch (read-only)
  - data access (read/write)
- Returns registered responses.
- Optionally zero-fills the RAM after reset.
- Sits between the CPUC core pipeline and the single-port RAM instance.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM word width.
- MEM_SIZE, 256, number of implemented words; must satisfy MEM_SIZE ≤ 2^ADDR_WIDTH.
- INIT_VALUE, 0, word written by the init sweep (DATA_WIDTH bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  ADDR_WIDTH  fetch address
- f_rsp_valid  out  1  fetch read data valid (1-cycle pulse)
- f_rsp_data  out  DATA_WIDTH  fetch read data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_wr  in  1  1=write, 0=read
- d_req_addr  in  ADDR_WIDTH  data address
- d_req_wdata  in  DATA_WIDTH  write data
- d_rsp_valid  out  1  data response (read data or write ack), 1-cycle pulse
- d_rsp_data  out  DATA_WIDTH  read data; write data echoed for writes
- init_busy  out  1  init sweep in progress
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_wren  out  1  to RAM write enable
- ram_data  out  DATA_WIDTH  to RAM write data
- ram_q  in  DATA_WIDTH  from RAM, combinational read of ram_address

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on rst_n=0.
- Reset values:
  - f_rsp_valid, d_rsp_valid = 0
  - f_rsp_data, d_rsp_data = 0
  - init_busy = 1 with feature, 0 without
  - last-grant flop = FETCH
  - init counter = 0
- States:
  - INIT: sweep.
  - RUN: arbitration.
  - INIT→RUN after the write to address MEM_SIZE-1.
  - No path back to INIT except reset.
- RUN arbitration, combinational grant, at most one grant per cycle:
  - Only one valid: grant it.
  - Both valid: grant the channel not granted last (round-robin); last-grant updates only on a grant.
  - x_req_ready = grant for that channel. The request is accepted when valid & ready in the same cycle.
  - Ready never asserts in INIT.
- RAM drive:
  - Granted cycle: ram_address = granted address; ram_wren = d_req_wr when data is granted, else 0; ram_data = d_req_wdata.
  - No grant: ram_address=0, ram_wren=0, ram_data=0.
  - Outputs are combinational from grant/state.
- Latency:
  - Read: ram_q is sampled in the accept cycle. x_rsp_valid=1 with x_rsp_data=sample on the next cycle.
  - Write: the RAM updates at the accept edge. d_rsp_valid=1 next cycle, d_rsp_data = d_req_wdata.
  - Throughput: 1 access/cycle total.
  - Read-after-write to the same address on the next cycle returns the new value.
- Response data: x_rsp_data holds its value until the next response on that channel.
- Out of range (addr ≥ MEM_SIZE):
  - Write: ram_wren suppressed.
  - Read: returns 0.
  - The response still pulses in both cases.
- No backpressure on responses. Requesters must sink each pulse.

Optional Feature:
- Macro: CPUC_RAM_CTRL_INIT_EN.
- Defined:
  - After reset release, the controller is in INIT.
  - Each cycle it drives ram_address = counter, ram_wren=1, ram_data=INIT_VALUE, and increments the counter.
  - init_busy=1 for exactly MEM_SIZE cycles, then 0; the state moves to RUN.
  - Requests are held off during INIT (ready=0).
  - rst_n asserted mid-sweep restarts the sweep from address 0.
- Not defined:
  - No init counter logic.
  - Reset enters RUN directly; init_busy is tied 0.
  - RAM contents are undefined until written.

Test Plan:
- Init sweep (macro on, MEM_SIZE=256): release reset, pre-load RAM with 0xFF. Required: init_busy high for exactly 256 cycles; all 256 words read back 0x00; no ready asserted during the sweep.
- Single data write then read: write addr 0x10 = 0xA5, read addr 0x10 the next cycle. Required: d_rsp_valid pulses on both responses; read returns 0xA5 one cycle after accept.
- Contention: f and d both valid for 4 cycles from reset. Required: grants D,F,D,F; f_rsp_data/d_rsp_data match pre-written words; ram_wren only on D write cycles.
- Back-to-back fetch: 8 consecutive fetches at 0..7 with d idle. Required: f_req_ready=1 every cycle; f_rsp_valid 8 consecutive cycles with the correct data.
- Out of range (MEM_SIZE=200): write 0x55 to addr 220, then read 220. Required: ram_wren=0 on the write; read returns 0x00; both responses still pulse.
- Async reset mid-sweep: assert rst_n=0 at sweep count 100 for 2 cycles. Required: outputs clear immediately; sweep restarts at address 0 and completes in 256 cycles.

Source files
------------

// File: rtl/cpuc_ram_ctrl.sv
// cpuc_ram_ctrl
//   Initiator side of the CPUC single-port RAM. Arbitrates an instruction-fetch
//   requester (read-only) and a data requester (read/write) onto one RAM port
//   with round-robin on contention, and returns registered 1-cycle responses.
//
//   Optional build macro: CPUC_RAM_CTRL_INIT_EN
//     defined   : after reset the RAM is swept with INIT_VALUE (MEM_SIZE cycles,
//                 init_busy high, requests held off), then normal operation.
//     undefined : reset goes straight to normal operation, init_busy tied 0.
//
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     f_req_valid/ready/addr     fetch request (valid/ready handshake)
//     f_rsp_valid/data           fetch response, valid is a 1-cycle pulse
//     d_req_valid/ready/wr/addr/wdata  data request
//     d_rsp_valid/data           data response (read data or echoed write data)
//     init_busy                  init sweep in progress
//     ram_address/wren/data      combinational drive into the RAM
//     ram_q                      combinational RAM read data of ram_address
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_INIT | sweeping INIT_VALUE into every implemented word
//   ST_RUN  | arbitrating fetch/data requests onto the RAM port
module cpuc_ram_ctrl #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MEM_SIZE   = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req_valid,
  output logic                  f_req_ready,
  input  logic [ADDR_WIDTH-1:0] f_req_addr,
  output logic                  f_rsp_valid,
  output logic [DATA_WIDTH-1:0] f_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_wr,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // One extra bit so MEM_SIZE == 2^ADDR_WIDTH compares correctly.
  localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                r_state;
  logic                  r_last_d;     // 1: last grant went to data channel
  logic                  w_run;
  logic                  w_gnt_f;
  logic                  w_gnt_d;
  logic                  w_f_inrange;
  logic                  w_d_inrange;
  logic [DATA_WIDTH-1:0] w_f_rd;
  logic [DATA_WIDTH-1:0] w_d_rd;
  logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef CPUC_RAM_CTRL_INIT_EN
  localparam state_t                LP_RST_STATE = ST_INIT;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST      = ADDR_WIDTH'(MEM_SIZE - 1);
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  assign w_init_addr = r_init_cnt;
`else
  localparam state_t LP_RST_STATE = ST_RUN;
  assign w_init_addr = '0;
`endif

  assign w_run     = (r_state == ST_RUN);
  assign init_busy = (r_state == ST_INIT);

  // Data wins when alone, or on contention when fetch had the last grant.
  assign w_gnt_d = w_run & d_req_valid & (~f_req_valid | ~r_last_d);
  assign w_gnt_f = w_run & f_req_valid & ~w_gnt_d;

  assign f_req_ready = w_gnt_f;
  assign d_req_ready = w_gnt_d;

  assign w_f_inrange = ({1'b0, f_req_addr} < LP_SIZE);
  assign w_d_inrange = ({1'b0, d_req_addr} < LP_SIZE);

  assign w_f_rd = w_f_inrange ? ram_q : '0;
  assign w_d_rd = d_req_wr ? d_req_wdata : (w_d_inrange ? ram_q : '0);

  always_comb begin
    ram_address = '0;
    ram_wren    = 1'b0;
    ram_data    = '0;
    if (r_state == ST_INIT) begin
      ram_address = w_init_addr;
      ram_wren    = 1'b1;
      ram_data    = INIT_VALUE;
    end else if (w_gnt_d) begin
      ram_address = d_req_addr;
      ram_wren    = d_req_wr & w_d_inrange;
      ram_data    = d_req_wdata;
    end else if (w_gnt_f) begin
      ram_address = f_req_addr;
      ram_data    = d_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LP_RST_STATE;
      r_last_d    <= 1'b0;
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
`ifdef CPUC_RAM_CTRL_INIT_EN
      r_init_cnt  <= '0;
`endif
    end else begin
      f_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
`ifdef CPUC_RAM_CTRL_INIT_EN
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == LP_LAST) r_state <= ST_RUN;
`else
          r_state <= ST_RUN;
`endif
        end
        ST_RUN: begin
          if (w_gnt_d) begin
            r_last_d    <= 1'b1;
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= w_d_rd;
          end else if (w_gnt_f) begin
            r_last_d    <= 1'b0;
            f_rsp_valid <= 1'b1;
            f_rsp_data  <= w_f_rd;
          end
        end
      endcase
    end
  end

endmodule
